// File: rtl/gated_event_counter.sv
// gated_event_counter
//   Modulo-MODULUS up/down counter fed by the gated enable qualifier. A small
//   IDLE/RUN/HALT run-control FSM decides when counting is allowed.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cnt_en     gated count qualifier
//   up_dn      1 = up, 0 = down
//   start      IDLE/HALT -> RUN
//   stop       RUN -> IDLE (wins over start in RUN)
//   clr        clears count, wrap_flag, tc and the edge detector; HALT -> IDLE
//   load       loads min(load_val, MODULUS-1) into count
//   load_val   load value
//   count      current count, always in 0..MODULUS-1
//   tc         one-cycle pulse aligned with the wrapped count
//   wrap_flag  sticky wrap indicator
//   running    FSM is in RUN
module gated_event_counter #(
  parameter int WIDTH        = 4,
  parameter int MODULUS      = 10,
  parameter int EDGE_MODE    = 0,
  parameter int HALT_ON_WRAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_flag,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_nxt;
  logic             cnt_en_d;
  logic             q, cnt_go, at_end, wrap;
  logic [WIDTH-1:0] load_sat, count_nxt;

  // Qualifier: level or rising edge of cnt_en. The edge register tracks
  // cnt_en in every state so a level already high at start is not an edge.
  always_comb begin
    q = cnt_en;
    if (EDGE_MODE != 0) q = cnt_en & ~cnt_en_d;
  end

  // clr and load both outrank counting, so a count step never coincides.
  assign cnt_go   = (state == RUN) && q && !clr && !load;
  assign at_end   = up_dn ? (count == MAX_CNT) : (count == '0);
  assign wrap     = cnt_go && at_end;
  assign load_sat = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  always_comb begin
    count_nxt = count;
    if (up_dn) count_nxt = at_end ? '0      : count + WIDTH'(1);
    else       count_nxt = at_end ? MAX_CNT : count - WIDTH'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
               else if (wrap && HALT_ON_WRAP != 0) state_nxt = HALT;
      HALT:    if (clr) state_nxt = IDLE;
               else if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_en_d  <= 1'b0;
      count     <= '0;
      tc        <= 1'b0;
      wrap_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_en_d <= clr ? 1'b0 : cnt_en;
      if (clr) begin
        count     <= '0;
        tc        <= 1'b0;
        wrap_flag <= 1'b0;
      end else if (load) begin
        count <= load_sat;
        tc    <= 1'b0;
      end else begin
        tc <= wrap;
        if (cnt_go) count <= count_nxt;
        if (wrap) wrap_flag <= 1'b1;
      end
    end
  end

  assign running = (state == RUN);

endmodule

// File: doc/gated_event_counter.md
Name: gated_event_counter

Overview:
- Modulo-N up/down event counter that sits directly downstream of the two-input AND enable gate in the counter design.
- Counts the gated enable qualifier `cnt_en` while a small run-control FSM allows it.
- Produces the count value, a one-cycle terminal-count pulse and a sticky wrap flag for the display/compare logic downstream.
- Supports synchronous load, clear, start/stop and optional halt-on-wrap.

Parameters:
- WIDTH, 4, width of the count register and of `load_val`/`count`.
- MODULUS, 10, count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- EDGE_MODE, 0, 0 = count every cycle `cnt_en`=1; 1 = count only on the rising edge of `cnt_en`.
- HALT_ON_WRAP, 0, 1 = FSM stops in HALT after a wrap; 0 = free-running wrap.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cnt_en  input  1  gated count qualifier (output of the AND enable gate).
- up_dn  input  1  1 = count up, 0 = count down; sampled on every counting cycle.
- start  input  1  pulse or level; moves the FSM from IDLE or HALT to RUN.
- stop  input  1  moves the FSM from RUN to IDLE.
- clr  input  1  synchronous clear of `count`, `wrap_flag` and the edge detector.
- load  input  1  synchronous load of `load_val` into `count`.
- load_val  input  WIDTH  load value; values >= MODULUS are reduced by taking MODULUS-1.
- count  output  WIDTH  current count.
- tc  output  1  one-cycle pulse on the cycle `count` wraps.
- wrap_flag  output  1  sticky; set on any wrap, cleared only by `rst` or `clr`.
- running  output  1  1 when the FSM is in RUN.

Behaviour:
- Reset (sampled at a clk edge with `rst`=1):
  - `count` = 0, `tc` = 0, `wrap_flag` = 0, `running` = 0.
  - FSM = IDLE; edge-detect register = 0.
  - Reset mid-count aborts immediately, with no tc pulse.
- FSM states IDLE, RUN, HALT; encoding is free, `running` = (state == RUN).
  - IDLE: `start` -> RUN.
  - RUN: `stop` -> IDLE. A wrap with HALT_ON_WRAP=1 -> HALT. Otherwise stay in RUN.
  - HALT: `start` -> RUN; `clr` also -> IDLE.
  - `start` and `stop` asserted together in RUN -> IDLE (stop wins). In IDLE, `start` wins.
- Count qualifier `q`:
  - EDGE_MODE=0: `q` = `cnt_en`.
  - EDGE_MODE=1: `q` = `cnt_en` & ~`cnt_en_d`, where `cnt_en_d` is `cnt_en` registered every cycle regardless of state.
  - Counting occurs only when state == RUN and `q` = 1.
- Priority per cycle: `rst` > `clr` > `load` > count.
  - `clr`: `count` <- 0, `wrap_flag` <- 0, `tc` <- 0, `cnt_en_d` <- 0.
  - `load`: `count` <- min(`load_val`, MODULUS-1); `tc` <- 0; `wrap_flag` unchanged; FSM state unchanged.
  - Up count: `count` = MODULUS-1 -> 0 with `tc`=1, else +1.
  - Down count: `count` = 0 -> MODULUS-1 with `tc`=1, else -1.
  - A wrap sets `wrap_flag` in the same cycle `tc` is asserted.
- Timing:
  - `tc` is registered and high exactly one cycle, aligned with the updated `count`.
  - Latency is 1 cycle from the qualifying edge to the `count` change.
  - No count in the cycle the FSM enters RUN; `start` takes effect for the next edge.
- Arithmetic is modulo MODULUS only; no intermediate value >= MODULUS ever appears on `count`.
- A direction change with `up_dn` between counts is legal and takes effect on the next count.

Test Plan:
- Reset: `rst`=1 for 2 cycles with `cnt_en`=1 -> `count`=0, `tc`=0, `wrap_flag`=0, `running`=0. Release, no `start` -> `count` stays 0.
- Up-wrap (MODULUS=10, EDGE_MODE=0): `start`, then `cnt_en`=1, `up_dn`=1 for 12 cycles -> `count` 1..9,0,1,2; `tc`=1 only on the cycle `count`=0; `wrap_flag`=1 thereafter.
- Down-wrap: `load` `load_val`=0, `up_dn`=0, one count -> `count`=9, `tc`=1. Next count -> `count`=8, `tc`=0.
- Edge mode (EDGE_MODE=1): `cnt_en` held high 5 cycles, low 1, high 3 -> `count` advances by exactly 2.
- Halt-on-wrap (HALT_ON_WRAP=1): `load` 9, count up once -> `count`=0, `tc`=1, `running`=0. Further `cnt_en` ignored. `start` -> `running`=1 and counting resumes.
- Priority/boundary: `clr`+`load`+`cnt_en` in the same cycle -> `count`=0, `wrap_flag`=0. `load_val`=15 with MODULUS=10 -> `count`=9. `stop`+`start` in RUN -> IDLE.
